mips_mc_ctrl_hs: RTL and testbench

//  Parametrised multi-cycle MIPS controller: next generation of the processor's control FSM.

---
 rtl/mips_mc_ctrl_hs.sv | 162 ++++++++++++++++
 tb/tb_mips_mc_ctrl_hs.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl_hs.sv
// Multi-cycle MIPS control FSM with memory ready handshake, access timeout trap,
// and retire/cycle counters. Control outputs decode combinationally from the state.
module mips_mc_ctrl_hs #(
  parameter int MEM_HS   = 1,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opCode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pcWrite,
  output logic             pcConditional,
  output logic             pcCondNE,
  output logic             IorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             IRWrite,
  output logic             regWrite,
  output logic             ALUSrcA,
  output logic [1:0]       regDst,
  output logic [1:0]       memtoreg,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic [3:0]       state,
  output logic             retire,
  output logic             trap,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXE   = 4'd6,  S_RWB    = 4'd7,
    S_BEQ    = 4'd8,  S_BNE    = 4'd9,  S_JMP    = 4'd10, S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12, S_JAL    = 4'd13, S_JR     = 4'd14, S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t           r_state;
  logic [7:0]       r_wait;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_ready;
  logic             w_mem_state;
  logic             w_timeout;
  logic             w_retire;

  // Handshake: a memory state holds its request (memRead/memWrite) every cycle
  // until mem_ready is seen high; that cycle completes the access and the FSM
  // moves on. With MEM_HS=0 every access completes in its first cycle.
  assign w_ready     = (MEM_HS == 0) ? 1'b1 : mem_ready;
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR);
  assign w_timeout   = (MEM_HS != 0) && w_mem_state && !mem_ready &&
                       (r_wait == 8'(WAIT_MAX));

  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEMWB, S_RWB, S_BEQ, S_BNE, S_JMP, S_JR, S_ADDIWB, S_JAL: w_retire = 1'b1;
      S_MEMWR: w_retire = w_ready;
      default: w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_FETCH;
      r_wait      <= 8'd0;
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (r_state != S_TRAP) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_retire)          r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      // The wait counter only runs while an access is stalled; leaving a memory
      // state or completing an access leaves it at zero for the next access.
      if (w_mem_state && !w_ready) r_wait <= r_wait + 8'd1;
      else                         r_wait <= 8'd0;
      case (r_state)
        S_FETCH: begin
          if (w_timeout)    r_state <= S_TRAP;
          else if (w_ready) r_state <= S_DECODE;
        end
        S_DECODE: begin
          case (opCode)
            OP_RTYPE:     r_state <= (funct == FN_JR) ? S_JR : S_REXE;
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_BEQ:       r_state <= S_BEQ;
            OP_BNE:       r_state <= S_BNE;
            OP_J:         r_state <= S_JMP;
            OP_JAL:       r_state <= S_JAL;
            OP_ADDI:      r_state <= S_ADDIEX;
            default:      r_state <= S_TRAP;
          endcase
        end
        S_MEMADR: r_state <= (opCode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD: begin
          if (w_timeout)    r_state <= S_TRAP;
          else if (w_ready) r_state <= S_MEMWB;
        end
        S_MEMWR: begin
          if (w_timeout)    r_state <= S_TRAP;
          else if (w_ready) r_state <= S_FETCH;
        end
        S_REXE:   r_state <= S_RWB;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pcWrite = 1'b0; pcConditional = 1'b0; pcCondNE = 1'b0; IorD = 1'b0;
    memRead = 1'b0; memWrite = 1'b0; IRWrite = 1'b0; regWrite = 1'b0;
    ALUSrcA = 1'b0; regDst = 2'b00; memtoreg = 2'b00; ALUSrcB = 2'b00;
    ALUOp = 2'b00; PCSrc = 2'b00;
    case (r_state)
      S_FETCH: begin
        memRead = 1'b1; ALUSrcB = 2'b01;
        IRWrite = w_ready; pcWrite = w_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      S_MEMRD:  begin memRead = 1'b1; IorD = 1'b1; end
      S_MEMWB:  begin regWrite = 1'b1; memtoreg = 2'b01; end
      S_MEMWR:  begin memWrite = 1'b1; IorD = 1'b1; end
      S_REXE:   begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
      S_RWB:    begin regWrite = 1'b1; regDst = 2'b01; end
      S_BEQ:    begin ALUSrcA = 1'b1; ALUOp = 2'b01; PCSrc = 2'b01; pcConditional = 1'b1; end
      S_BNE:    begin ALUSrcA = 1'b1; ALUOp = 2'b01; PCSrc = 2'b01; pcCondNE = 1'b1; end
      S_JMP:    begin pcWrite = 1'b1; PCSrc = 2'b10; end
      S_JR:     begin pcWrite = 1'b1; PCSrc = 2'b11; end
      S_ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      S_ADDIWB: regWrite = 1'b1;
      S_JAL: begin
        regWrite = 1'b1; regDst = 2'b10; memtoreg = 2'b10;
        pcWrite = 1'b1; PCSrc = 2'b10;
      end
      default: ;
    endcase
  end

  assign state     = r_state;
  assign retire    = w_retire;
  assign trap      = (r_state == S_TRAP);
  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_mips_mc_ctrl_hs.sv
// Bench for mips_mc_ctrl_hs (MEM_HS=1, WAIT_MAX=4, CNT_W=4): directed instruction
// sequences push per-cycle expectations; a negedge monitor pops and compares them.
module tb_mips_mc_ctrl_hs;

  localparam int CW = 4;
  localparam int EW = 4 + 19 + 1 + 1 + CW + CW;

  typedef struct packed {
    logic [3:0]    st;
    logic [18:0]   ctl;
    logic          ret;
    logic          trp;
    logic [CW-1:0] cyc;
    logic [CW-1:0] ins;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opCode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic mem_ready = 1'b0;
  logic pcWrite, pcConditional, pcCondNE, IorD, memRead, memWrite, IRWrite;
  logic regWrite, ALUSrcA, retire, trap;
  logic [1:0] regDst, memtoreg, ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;
  logic [CW-1:0] cycle_cnt, instr_cnt;
  logic [18:0] act_ctl;

  logic [EW-1:0] exp_q[$];
  logic [CW-1:0] exp_cyc = '0;
  logic [CW-1:0] exp_ins = '0;
  int n_chk = 0;
  int n_fail = 0;

  mips_mc_ctrl_hs #(.MEM_HS(1), .WAIT_MAX(4), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .opCode(opCode), .funct(funct), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .pcConditional(pcConditional), .pcCondNE(pcCondNE),
    .IorD(IorD), .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite),
    .regWrite(regWrite), .ALUSrcA(ALUSrcA), .regDst(regDst), .memtoreg(memtoreg),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .state(state),
    .retire(retire), .trap(trap), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  assign act_ctl = {pcWrite, pcConditional, pcCondNE, IorD, memRead, memWrite,
                    IRWrite, regWrite, ALUSrcA, regDst, memtoreg, ALUSrcB, ALUOp, PCSrc};

  // clock/reset block
  always #5 clk = ~clk;

  // Expected control word for a state, straight from the control table.
  function automatic logic [18:0] ctl_of(input logic [3:0] st, input logic rdy);
    logic pw, pc, pn, iod, mr, mw, ir, rw, sa;
    logic [1:0] rd, mt, sb, ao, ps;
    {pw, pc, pn, iod, mr, mw, ir, rw, sa} = '0;
    {rd, mt, sb, ao, ps} = '0;
    case (st)
      4'd0:  begin mr = 1; sb = 2'b01; ir = rdy; pw = rdy; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; mt = 2'b01; end
      4'd5:  begin mw = 1; iod = 1; end
      4'd6:  begin sa = 1; ao = 2'b10; end
      4'd7:  begin rw = 1; rd = 2'b01; end
      4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pc = 1; end
      4'd9:  begin sa = 1; ao = 2'b01; ps = 2'b01; pn = 1; end
      4'd10: begin pw = 1; ps = 2'b10; end
      4'd11: begin sa = 1; sb = 2'b10; end
      4'd12: rw = 1;
      4'd13: begin rw = 1; rd = 2'b10; mt = 2'b10; pw = 1; ps = 2'b10; end
      4'd14: begin pw = 1; ps = 2'b11; end
      default: ;
    endcase
    return {pw, pc, pn, iod, mr, mw, ir, rw, sa, rd, mt, sb, ao, ps};
  endfunction

  // driver tasks: each call covers one clock cycle
  task automatic cyc(input logic [3:0] st, input logic rdy, input logic ret);
    exp_t e;
    mem_ready = rdy;
    e.st = st; e.ctl = ctl_of(st, rdy); e.ret = ret; e.trp = (st == 4'd15);
    e.cyc = exp_cyc; e.ins = exp_ins;
    exp_q.push_back(e);
    if (st != 4'd15) exp_cyc = exp_cyc + 1'b1;
    if (ret) exp_ins = exp_ins + 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic rst_cycles(input int n);
    exp_t e;
    rst = 1'b0;
    mem_ready = 1'b0;
    exp_cyc = '0;
    exp_ins = '0;
    for (int i = 0; i < n; i++) begin
      e.st = 4'd0; e.ctl = ctl_of(4'd0, 1'b0); e.ret = 1'b0; e.trp = 1'b0;
      e.cyc = '0; e.ins = '0;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    rst = 1'b1;
  endtask

  task automatic set_op(input logic [5:0] o, input logic [5:0] f);
    opCode = o;
    funct = f;
  endtask

  task automatic i_add();  set_op(6'b000000, 6'b100000); cyc(0,1,0); cyc(1,1,0); cyc(6,1,0); cyc(7,1,1); endtask
  task automatic i_lw();   set_op(6'b100011, 6'b000000); cyc(0,1,0); cyc(1,1,0); cyc(2,1,0); cyc(3,1,0); cyc(4,1,1); endtask
  task automatic i_sw();   set_op(6'b101011, 6'b000000); cyc(0,1,0); cyc(1,1,0); cyc(2,1,0); cyc(5,1,1); endtask
  task automatic i_beq();  set_op(6'b000100, 6'b000000); cyc(0,1,0); cyc(1,1,0); cyc(8,1,1); endtask
  task automatic i_bne();  set_op(6'b000101, 6'b000000); cyc(0,1,0); cyc(1,1,0); cyc(9,1,1); endtask
  task automatic i_j();    set_op(6'b000010, 6'b000000); cyc(0,1,0); cyc(1,1,0); cyc(10,1,1); endtask
  task automatic i_jal();  set_op(6'b000011, 6'b000000); cyc(0,1,0); cyc(1,1,0); cyc(13,1,1); endtask
  task automatic i_jr();   set_op(6'b000000, 6'b001000); cyc(0,1,0); cyc(1,1,0); cyc(14,1,1); endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("ctl", 32'(act_ctl), 32'(e.ctl));
        chk("retire", 32'(retire), 32'(e.ret));
        chk("trap", 32'(trap), 32'(e.trp));
        chk("cycle_cnt", 32'(cycle_cnt), 32'(e.cyc));
        chk("instr_cnt", 32'(instr_cnt), 32'(e.ins));
      end
    end
  end

  initial begin
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst_cycles(2);

    // zero-wait program: add, lw, sw, beq, j
    i_add(); i_lw(); i_sw(); i_beq(); i_j();

    // fetch stalled 3 cycles, then addi
    set_op(6'b001000, 6'b000000);
    cyc(0,0,0); cyc(0,0,0); cyc(0,0,0); cyc(0,1,0); cyc(1,1,0); cyc(11,1,0); cyc(12,1,1);

    i_bne(); i_jal(); i_jr();

    // lw with two stalled read cycles
    set_op(6'b100011, 6'b000000);
    cyc(0,1,0); cyc(1,1,0); cyc(2,1,0); cyc(3,0,0); cyc(3,0,0); cyc(3,1,0); cyc(4,1,1);

    // sw whose ready arrives the cycle the wait counter reaches WAIT_MAX
    set_op(6'b101011, 6'b000000);
    cyc(0,1,0); cyc(1,1,0); cyc(2,1,0);
    cyc(5,0,0); cyc(5,0,0); cyc(5,0,0); cyc(5,0,0); cyc(5,1,1);

    // five more retirements take instr_cnt to 16, wrapping to 0
    for (int i = 0; i < 5; i++) i_j();
    i_add();

    // lw read that never completes: five MEMRD cycles then TRAP, counters frozen
    set_op(6'b100011, 6'b000000);
    cyc(0,1,0); cyc(1,1,0); cyc(2,1,0);
    for (int i = 0; i < 5; i++) cyc(3,0,0);
    cyc(15,1,0); cyc(15,0,0); cyc(15,1,0);

    // illegal opcode traps after decode; reset releases it
    rst_cycles(2);
    set_op(6'b111111, 6'b000000);
    cyc(0,1,0); cyc(1,1,0); cyc(15,1,0); cyc(15,1,0); cyc(15,0,0);
    rst_cycles(1);
    i_beq();

    // reset asserted in the middle of a stalled read
    set_op(6'b100011, 6'b000000);
    cyc(0,1,0); cyc(1,1,0); cyc(2,1,0); cyc(3,0,0);
    rst_cycles(2);
    i_add(); i_sw();

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
